// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer, the IF-stage PC mux and the CSR unit.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        StBoot  = 3'd0,
        StRun   = 3'd1,
        StDrain = 3'd2,
        StSleep = 3'd3,
        StTrap  = 3'd4
    } ctrl_state_e;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_TRAP = 2'b10;
    localparam logic [1:0] PC_MEPC = 2'b11;

    // Cycles needed for the WFI to retire through MEM and WB before sleeping.
    localparam int unsigned DRAIN_CYCLES = 2;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Condition inputs and per-stage control outputs of the pipeline sequencer.
interface pipe_ctrl_if;

    logic       hz_stall;
    logic       br_taken;
    logic       mret_ex;
    logic       wfi_ex;
    logic       irq_pending;
    logic       im_wait;
    logic       dm_wait;

    logic       pc_en;
    logic [1:0] pc_sel;
    logic       if_id_en;
    logic       id_ex_en;
    logic       ex_m_en;
    logic       m_wb_en;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ex_m_flush;
    logic       trap_take;
    logic       boot_done;
    logic [2:0] ctrl_state;

    modport master (
        input  hz_stall, br_taken, mret_ex, wfi_ex, irq_pending, im_wait, dm_wait,
        output pc_en, pc_sel, if_id_en, id_ex_en, ex_m_en, m_wb_en,
        output if_id_flush, id_ex_flush, ex_m_flush, trap_take, boot_done, ctrl_state
    );

    modport slave (
        output hz_stall, br_taken, mret_ex, wfi_ex, irq_pending, im_wait, dm_wait,
        input  pc_en, pc_sel, if_id_en, id_ex_en, ex_m_en, m_wb_en,
        input  if_id_flush, id_ex_flush, ex_m_flush, trap_take, boot_done, ctrl_state
    );

endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: boot hold, hazard/memory freeze,
// redirects, trap entry and the WFI drain/sleep sequence, sharing one counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES = 6,
    parameter int unsigned CNT_W       = 3
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] BootLast  = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DrainInit = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             boot_done_q, boot_done_d;

    logic       freeze;
    logic       pc_en, if_id_en, id_ex_en, ex_m_en, m_wb_en;
    logic       if_id_flush, id_ex_flush, ex_m_flush, trap_take;
    logic [1:0] pc_sel;

    assign freeze = bus.im_wait | bus.dm_wait;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        boot_done_d = boot_done_q;
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_m_en     = 1'b0;
        m_wb_en     = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_m_flush  = 1'b0;
        trap_take   = 1'b0;
        pc_sel      = PC_SEQ;

        unique case (state_q)
            StBoot: begin
                cnt_d = cnt_q + CntOne;
                if (cnt_q == BootLast) begin
                    state_d     = StRun;
                    cnt_d       = '0;
                    boot_done_d = 1'b1;
                end
            end
            StRun: begin
                if (!freeze) begin
                    {pc_en, if_id_en, id_ex_en, ex_m_en, m_wb_en} = 5'b11111;
                    // A redirect wins over an interrupt; the irq is taken next cycle.
                    if (bus.br_taken) begin
                        pc_sel      = PC_BR;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (bus.mret_ex) begin
                        pc_sel      = PC_MEPC;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (bus.irq_pending) begin
                        pc_sel      = PC_TRAP;
                        trap_take   = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        ex_m_flush  = 1'b1;
                        state_d     = StTrap;
                    end else if (bus.wfi_ex) begin
                        pc_en       = 1'b0;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        cnt_d       = DrainInit;
                        state_d     = StDrain;
                    end else if (bus.hz_stall) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
            end
            StTrap: begin
                if (!freeze) begin
                    {pc_en, if_id_en, id_ex_en, ex_m_en, m_wb_en} = 5'b11111;
                    if_id_flush = 1'b1;
                    state_d     = StRun;
                end
            end
            StDrain: begin
                if (!freeze) begin
                    ex_m_en    = 1'b1;
                    m_wb_en    = 1'b1;
                    ex_m_flush = 1'b1;
                    cnt_d      = cnt_q - CntOne;
                    if (cnt_q == CntOne) begin
                        state_d = StSleep;
                    end
                end
            end
            StSleep: begin
                if (bus.irq_pending) begin
                    pc_sel      = PC_TRAP;
                    pc_en       = 1'b1;
                    trap_take   = 1'b1;
                    if_id_en    = 1'b1;
                    if_id_flush = 1'b1;
                    state_d     = StTrap;
                end
            end
            default: begin
                state_d = StBoot;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StBoot;
            cnt_q       <= '0;
            boot_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            boot_done_q <= boot_done_d;
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.pc_sel      = pc_sel;
    assign bus.if_id_en    = if_id_en;
    assign bus.id_ex_en    = id_ex_en;
    assign bus.ex_m_en     = ex_m_en;
    assign bus.m_wb_en     = m_wb_en;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_flush = id_ex_flush;
    assign bus.ex_m_flush  = ex_m_flush;
    assign bus.trap_take   = trap_take;
    assign bus.boot_done   = boot_done_q;
    assign bus.ctrl_state  = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations, then random traffic
// compared every cycle against a flag/countdown model of the sequencing rules.
module tb_pipe_ctrl;

    localparam int unsigned BOOT = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Model: remaining hold/drain cycles plus mode flags.
    int   boot_left;
    int   drain_left;
    bit   booted, sleeping, in_trap;

    pipe_ctrl_if pif ();

    pipe_ctrl #(
        .BOOT_CYCLES(BOOT),
        .CNT_W      (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(pif)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] dut_vec();
        return {pif.ctrl_state, pif.boot_done, pif.pc_sel, pif.pc_en, pif.if_id_en,
                pif.id_ex_en, pif.ex_m_en, pif.m_wb_en, pif.if_id_flush, pif.id_ex_flush,
                pif.ex_m_flush, pif.trap_take};
    endfunction

    function automatic logic [14:0] model_vec();
        logic [2:0] st;
        logic [1:0] sel;
        logic [4:0] en;
        logic [2:0] fl;
        logic       tt;
        bit         frz;
        st = 3'd1; sel = 2'b00; en = 5'b0; fl = 3'b0; tt = 1'b0;
        frz = pif.im_wait || pif.dm_wait;
        if (!rst || boot_left > 0) begin
            st = 3'd0;
        end else if (sleeping) begin
            st = 3'd3;
            if (pif.irq_pending) begin
                sel = 2'b10; en = 5'b11000; fl = 3'b100; tt = 1'b1;
            end
        end else if (in_trap) begin
            st = 3'd4;
            if (!frz) begin
                en = 5'b11111; fl = 3'b100;
            end
        end else if (drain_left > 0) begin
            st = 3'd2;
            if (!frz) begin
                en = 5'b00011; fl = 3'b001;
            end
        end else if (!frz) begin
            en = 5'b11111;
            if (pif.br_taken) begin
                sel = 2'b01; fl = 3'b110;
            end else if (pif.mret_ex) begin
                sel = 2'b11; fl = 3'b110;
            end else if (pif.irq_pending) begin
                sel = 2'b10; fl = 3'b111; tt = 1'b1;
            end else if (pif.wfi_ex) begin
                en = 5'b01111; fl = 3'b110;
            end else if (pif.hz_stall) begin
                en = 5'b00111; fl = 3'b010;
            end
        end
        return {st, logic'(booted && rst), sel, en, fl, tt};
    endfunction

    task automatic model_reset();
        boot_left = BOOT; drain_left = 0;
        booted = 0; sleeping = 0; in_trap = 0;
    endtask

    task automatic model_step();
        bit frz;
        frz = pif.im_wait || pif.dm_wait;
        if (boot_left > 0) begin
            boot_left--;
            if (boot_left == 0) booted = 1;
        end else if (sleeping) begin
            if (pif.irq_pending) begin
                sleeping = 0; in_trap = 1;
            end
        end else if (frz) begin
        end else if (in_trap) begin
            in_trap = 0;
        end else if (drain_left > 0) begin
            drain_left--;
            if (drain_left == 0) sleeping = 1;
        end else if (!pif.br_taken && !pif.mret_ex) begin
            if (pif.irq_pending) in_trap = 1;
            else if (pif.wfi_ex) drain_left = 2;
        end
    endtask

    task automatic check_model();
        logic [14:0] a, e;
        a = dut_vec();
        e = model_vec();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL model_cmp t=%0t got %b want %b", $time, a, e);
        end
    endtask

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
        end
    endtask

    // Drive at the negedge, then compare once the combinational outputs settle.
    task automatic cyc(input bit hz, input bit br, input bit mr, input bit wf,
                       input bit irq, input bit im, input bit dm);
        pif.hz_stall = hz; pif.br_taken = br; pif.mret_ex = mr; pif.wfi_ex = wf;
        pif.irq_pending = irq; pif.im_wait = im; pif.dm_wait = dm;
        #1;
        check_model();
    endtask

    task automatic adv();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Called mid-cycle after cyc(): asserts reset without a clock edge.
    task automatic async_reset();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_model();
        lit("reset_vec", int'(dut_vec()), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            adv();
        end
    endtask

    initial begin
        model_reset();
        pif.hz_stall = 0; pif.br_taken = 0; pif.mret_ex = 0; pif.wfi_ex = 0;
        pif.irq_pending = 0; pif.im_wait = 0; pif.dm_wait = 0;
        #1;
        check_model();
        lit("por_vec", int'(dut_vec()), 0);
        @(negedge clk);
        rst = 1'b1;

        // Boot hold, then RUN with boot_done; async reset at cycle 10.
        for (int c = 0; c < 10; c++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            if (c < BOOT) lit("boot_pc_en", int'(pif.pc_en), 0);
            if (c == BOOT) begin
                lit("boot_end_pc_en", int'(pif.pc_en), 1);
                lit("boot_end_done", int'(pif.boot_done), 1);
            end
            adv();
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        lit("pre_rst_pc_en", int'(pif.pc_en), 1);
        async_reset();
        lit("rst_pc_en", int'(pif.pc_en), 0);
        idle(BOOT);

        // Load-use stall, then the same with a data-memory wait.
        cyc(1, 0, 0, 0, 0, 0, 0);
        lit("lu_pc_en", int'(pif.pc_en), 0);
        lit("lu_if_id_en", int'(pif.if_id_en), 0);
        lit("lu_id_ex_flush", int'(pif.id_ex_flush), 1);
        lit("lu_ex_m_en", int'(pif.ex_m_en), 1);
        adv();
        cyc(1, 0, 0, 0, 0, 0, 1);
        lit("lu_frz_en", int'({pif.pc_en, pif.if_id_en, pif.id_ex_en, pif.ex_m_en,
                               pif.m_wb_en}), 0);
        lit("lu_frz_flush", int'(pif.id_ex_flush), 0);
        adv();

        // Branch defers a simultaneous interrupt.
        cyc(0, 1, 0, 0, 1, 0, 0);
        lit("bi_sel_br", int'(pif.pc_sel), 1);
        lit("bi_no_trap", int'(pif.trap_take), 0);
        adv();
        cyc(0, 0, 0, 0, 1, 0, 0);
        lit("bi_sel_trap", int'(pif.pc_sel), 2);
        lit("bi_trap", int'(pif.trap_take), 1);
        lit("bi_ex_m_flush", int'(pif.ex_m_flush), 1);
        adv();
        cyc(0, 0, 0, 0, 1, 0, 0);
        lit("bi_trap_state", int'(pif.ctrl_state), 4);
        lit("bi_trap_ifflush", int'(pif.if_id_flush), 1);
        lit("bi_trap_once", int'(pif.trap_take), 0);
        adv();
        cyc(0, 0, 0, 0, 0, 0, 0);
        lit("bi_run", int'(pif.ctrl_state), 1);
        adv();

        // MRET.
        cyc(0, 0, 1, 0, 0, 0, 0);
        lit("mret_sel", int'(pif.pc_sel), 3);
        lit("mret_flush", int'({pif.if_id_flush, pif.id_ex_flush}), 3);
        lit("mret_no_trap", int'(pif.trap_take), 0);
        adv();

        // WFI drain with a 3-cycle freeze at the first drain cycle, sleep, wake.
        cyc(0, 0, 0, 1, 0, 0, 0);
        lit("wfi_pc_en", int'(pif.pc_en), 0);
        lit("wfi_flush", int'({pif.if_id_flush, pif.id_ex_flush}), 3);
        adv();
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1);
            lit("drain_frz_state", int'(pif.ctrl_state), 2);
            lit("drain_frz_cnt", int'(dut.cnt_q), 2);
            lit("drain_frz_en", int'({pif.ex_m_en, pif.m_wb_en}), 0);
            adv();
        end
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            lit("drain_state", int'(pif.ctrl_state), 2);
            lit("drain_ex_m_flush", int'(pif.ex_m_flush), 1);
            adv();
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 0, 0, 0, 1, 0);
            lit("sleep_state", int'(pif.ctrl_state), 3);
            lit("sleep_pc_en", int'(pif.pc_en), 0);
            adv();
        end
        cyc(0, 0, 0, 0, 1, 0, 0);
        lit("wake_trap", int'(pif.trap_take), 1);
        lit("wake_sel", int'(pif.pc_sel), 2);
        adv();
        cyc(0, 0, 0, 0, 0, 0, 0);
        lit("wake_trap_state", int'(pif.ctrl_state), 4);
        adv();
        cyc(0, 0, 0, 0, 0, 0, 0);
        lit("wake_run", int'(pif.ctrl_state), 1);
        adv();

        // Random traffic with occasional mid-operation resets.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 12,
                $urandom_range(0, 99) < 8,  $urandom_range(0, 99) < 10,
                $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 8,
                $urandom_range(0, 99) < 8);
            if ($urandom_range(0, 599) == 0) async_reset();
            else adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
